fir_mac_sequencer: RTL and testbench
====================================

# fir_mac_sequencer

Sequencer that turns the shared registered ALU into a direct-form FIR filter. It holds the sample delay line and coefficient bank. For each accepted input sample it issues one multiply per tap to the ALU and accumulates the returned products at full precision. It sits between the sample input stream and the filter output stream, and owns the ALU's op_sel/a/b inputs.

## Interface
Parameters:
- TAPS, 8, number of filter taps (≥2)
- ACC_W, 35, accumulator/output width; must be ≥ 32 + clog2(TAPS)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer can accept a sample
- in_data  in  16  signed input sample
- out_valid  out  1  filter result valid
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_W  signed filter result
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  coefficient index
- coef_data  in  16  signed coefficient value
- busy  out  1  high whenever state ≠ IDLE
- alu_op_sel  out  2  to ALU op_sel
- alu_a  out  16  to ALU operand a (sample)
- alu_b  out  16  to ALU operand b (coefficient)
- alu_result  in  32  from ALU result (registered, 1-cycle latency)

## Operation
- Storage: x[0..TAPS-1] delay line, c[0..TAPS-1] coefficients, acc[ACC_W-1:0], tap counter k, 1-bit prod_pending.
- States: IDLE, ISSUE, DRAIN, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: x[0]←in_data, x[i]←x[i-1]; acc←0; k←0; go to ISSUE.
  - coef_we writes c[coef_addr]←coef_data in IDLE only. coef_we in any other state is ignored.
- ISSUE:
  - Drive alu_op_sel=2'b01, alu_a=x[k], alu_b=c[k], using the already-shifted delay line. k increments each cycle.
  - At k=TAPS-1, go to DRAIN.
  - prod_pending is set each ISSUE cycle.
- Accumulation: in any cycle with prod_pending=1, acc←acc+sext(alu_result). prod_pending is then cleared unless set again by ISSUE.
- DRAIN: the last product is accumulated, then go to OUT.
- OUT:
  - out_valid=1, out_data=acc, both held stable.
  - On out_ready, go to IDLE.
- Outside ISSUE: alu_op_sel=2'b11 (ALU outputs 0), alu_a=0, alu_b=0.
- Arithmetic:
  - Products are sign-extended from 32 to ACC_W.
  - The sum wraps modulo 2^ACC_W. With the default widths no overflow is possible: the worst case is 8·2^30 = 2^33.
- in_ready = (state==IDLE) & ~rst. in_valid outside IDLE is not consumed, and in_data is not sampled.

## Timing
- Reset (async):
  - state=IDLE, x[]=0, c[]=0, acc=0, k=0, prod_pending=0.
  - out_valid=0, out_data=0, busy=0, alu_op_sel=2'b11, alu_a=alu_b=0.
- Accept edge E0:
  - ISSUE tap k occupies the cycle after edge E0+k, for k=0..TAPS-1.
  - The ALU registers product k at edge E0+k+1.
  - The product is added to acc at edge E0+k+2.
- DRAIN is entered at edge E_TAPS. OUT is entered at E_TAPS+1.
- out_valid rises TAPS+1 edges after accept (9 for TAPS=8).
- Minimum sample period is TAPS+3 cycles with out_ready held high. OUT→IDLE takes one edge, and the next accept takes one more.
- Reset mid-operation aborts immediately: no out_valid, partial acc discarded. The ALU shares rst, so no stale product arrives afterward.
- Simultaneous coef_we and accept in IDLE: the write completes. The accepted sample's computation uses the new coefficient.

## Test plan
- Impulse: c={1,2,…,8}, input 1 then seven 0s.
  - Outputs are 1,2,3,4,5,6,7,8.
  - A ninth sample 0 gives 0.
- Worst-case magnitude: all c=-32768, eight samples of -32768.
  - 8th output is 8589934592 (2^33), positive, no wrap.
- Latency/ALU sequence: single accept.
  - alu_op_sel=01 for exactly 8 consecutive cycles, with alu_a/alu_b matching x[k]/c[k], k=0..7.
  - out_valid rises at the 9th edge after accept.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1.
  - out_data stays stable, in_ready stays 0, busy stays 1, and the pending sample is not consumed.
  - After out_ready the sample is accepted 2 edges later.
- Coefficient lockout: write c[0]=100 during ISSUE.
  - c[0] is unchanged, and the current and next results use the old value.
- Reset mid-ISSUE: assert rst at k=4.
  - All outputs return to reset values, and no out_valid occurs.
  - After reset, loading c={1,…,8} and driving an impulse reproduces the impulse result.

Source files
------------

// File: rtl/fir_mac_sequencer_if.sv
// -----------------------------------------------------------------------------
// fir_mac_sequencer_if
//
// Bundles every signal of the FIR MAC sequencer except clk/rst:
//   sample input stream  : in_valid, in_ready, in_data[15:0]
//   result output stream : out_valid, out_ready, out_data[ACC_W-1:0]
//   coefficient port     : coef_we, coef_addr[clog2(TAPS)-1:0], coef_data[15:0]
//   status               : busy
//   shared ALU           : alu_op_sel[1:0], alu_a[15:0], alu_b[15:0],
//                          alu_result[31:0] (registered, 1-cycle latency)
//
// Modports:
//   slave  - the sequencer itself
//   master - the surrounding system (source, sink, coefficient loader, ALU)
// -----------------------------------------------------------------------------
interface fir_mac_sequencer_if #(
   parameter int TAPS  = 8,
   parameter int ACC_W = 35
);
   localparam int AW = $clog2(TAPS);

   logic              in_valid;
   logic              in_ready;
   logic [15:0]       in_data;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;
   logic              coef_we;
   logic [AW-1:0]     coef_addr;
   logic [15:0]       coef_data;
   logic              busy;
   logic [1:0]        alu_op_sel;
   logic [15:0]       alu_a;
   logic [15:0]       alu_b;
   logic [31:0]       alu_result;

   modport slave (
      input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
             alu_result,
      output in_ready, out_valid, out_data, busy, alu_op_sel, alu_a, alu_b
   );

   modport master (
      output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
             alu_result,
      input  in_ready, out_valid, out_data, busy, alu_op_sel, alu_a, alu_b
   );
endinterface

// File: rtl/fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// fir_mac_sequencer
//
// Turns the shared registered ALU into a direct-form FIR filter. Holds the
// sample delay line x[] and the coefficient bank c[]. For each accepted sample
// it issues one multiply per tap (alu_a = x[k], alu_b = c[k]) and accumulates
// the returned 32-bit products, sign-extended, into an ACC_W-bit accumulator.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset (shared with the ALU)
//   bus  - fir_mac_sequencer_if.slave: sample in stream, result out stream,
//          coefficient write port, busy, ALU operand/result signals
//
// Parameters:
//   TAPS  - number of taps (>= 2)
//   ACC_W - accumulator / result width (>= 32 + clog2(TAPS))
//
// Sequence per sample (E0 = accept edge):
//   ISSUE for TAPS cycles, DRAIN one cycle for the final ALU product,
//   then OUT holds the result until out_ready. out_valid rises at E0+TAPS+1.
// -----------------------------------------------------------------------------
module fir_mac_sequencer #(
   parameter int TAPS  = 8,
   parameter int ACC_W = 35
) (
   input  logic                 clk,
   input  logic                 rst,
   fir_mac_sequencer_if.slave   bus
);

   localparam int DATA_W = 16;
   localparam int COEF_W = 16;
   localparam int PROD_W = 32;
   localparam int KW     = $clog2(TAPS);
   // Coefficient bank is sized to the full address range so any coef_addr
   // value is a legal write target, even for non power-of-two TAPS.
   localparam int CDEPTH = 1 << KW;

   localparam logic [1:0] OP_MUL  = 2'b01;
   localparam logic [1:0] OP_ZERO = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t                     state;
   state_t                     state_nxt;

   logic signed [DATA_W-1:0]   x [TAPS];
   logic signed [COEF_W-1:0]   c [CDEPTH];
   logic signed [ACC_W-1:0]    acc;
   logic [KW-1:0]              k;
   logic                       prod_pending;

   logic                       accept;
   logic                       coef_wr;
   logic                       last_tap;

   // Full-precision sign extension of an ALU product into the accumulator.
   function automatic logic signed [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
      return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
   endfunction

   assign accept   = (state == IDLE) && bus.in_valid;
   // Coefficients are frozen while a sample is in flight so a result is
   // never computed from a mix of old and new coefficients.
   assign coef_wr  = (state == IDLE) && bus.coef_we;
   assign last_tap = (k == KW'(TAPS - 1));

   // ---- state register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---- next state and outputs ----
   always_comb begin
      state_nxt      = state;
      bus.in_ready   = 1'b0;
      bus.out_valid  = 1'b0;
      bus.out_data   = '0;
      bus.busy       = 1'b1;
      bus.alu_op_sel = OP_ZERO;
      bus.alu_a      = '0;
      bus.alu_b      = '0;

      unique case (state)
         IDLE: begin
            bus.busy     = 1'b0;
            bus.in_ready = ~rst;
            if (accept) begin
               state_nxt = ISSUE;
            end
         end

         ISSUE: begin
            // The delay line was already shifted at the accept edge, so
            // x[0] is the newest sample here.
            bus.alu_op_sel = OP_MUL;
            bus.alu_a      = x[k];
            bus.alu_b      = c[k];
            if (last_tap) begin
               state_nxt = DRAIN;
            end
         end

         DRAIN: begin
            // Last product is being added this cycle.
            state_nxt = OUT;
         end

         OUT: begin
            bus.out_valid = 1'b1;
            bus.out_data  = acc;
            if (bus.out_ready) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---- delay line, coefficients, tap counter ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TAPS; i++) begin
            x[i] <= '0;
         end
         for (int i = 0; i < CDEPTH; i++) begin
            c[i] <= '0;
         end
         k <= '0;
      end else begin
         // A write that coincides with an accept lands before the first
         // ISSUE cycle reads c[], so the new value is used.
         if (coef_wr) begin
            c[bus.coef_addr] <= bus.coef_data;
         end

         if (accept) begin
            x[0] <= bus.in_data;
            for (int i = 1; i < TAPS; i++) begin
               x[i] <= x[i-1];
            end
         end

         if (accept) begin
            k <= '0;
         end else if (state == ISSUE) begin
            k <= k + 1'b1;
         end
      end
   end

   // ---- product accumulation (one cycle behind the ALU) ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc          <= '0;
         prod_pending <= 1'b0;
      end else begin
         // Every ISSUE cycle produces exactly one ALU result one edge later.
         prod_pending <= (state == ISSUE);

         if (accept) begin
            acc <= '0;
         end else if (prod_pending) begin
            acc <= acc + sext_prod(bus.alu_result);
         end
      end
   end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_sequencer
//
// Self-checking bench for fir_mac_sequencer. Provides a registered ALU model
// (op 01 = signed 16x16 multiply, otherwise 0) and a convolution reference
// model: expected output = sum over taps of coef[i] * (i-th most recent
// sample), wrapped to ACC_W bits.
// -----------------------------------------------------------------------------
module tb_fir_mac_sequencer;

   localparam int TAPS  = 8;
   localparam int ACC_W = 35;
   localparam int AW    = $clog2(TAPS);

   logic clk;
   logic rst;

   fir_mac_sequencer_if #(.TAPS(TAPS), .ACC_W(ACC_W)) bus ();

   fir_mac_sequencer #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered ALU, shares rst with the sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.alu_result <= '0;
      end else if (bus.alu_op_sel == 2'b01) begin
         bus.alu_result <= {{16{bus.alu_a[15]}}, bus.alu_a} * {{16{bus.alu_b[15]}}, bus.alu_b};
      end else begin
         bus.alu_result <= '0;
      end
   end

   int n_cmp;
   int n_bad;

   // Reference model state: newest sample at the front of the queue.
   logic signed [15:0] m_hist[$];
   logic signed [15:0] m_coef[TAPS];

   function automatic logic [ACC_W-1:0] model_push(input logic signed [15:0] d);
      longint s;
      m_hist.push_front(d);
      if (m_hist.size() > TAPS) void'(m_hist.pop_back());
      s = 0;
      for (int i = 0; i < m_hist.size(); i++) begin
         s += longint'(m_hist[i]) * longint'(m_coef[i]);
      end
      return s[ACC_W-1:0];
   endfunction

   function automatic logic signed [15:0] hist_at(input int i);
      if (i < m_hist.size()) return m_hist[i];
      return 16'sd0;
   endfunction

   task automatic model_reset();
      m_hist.delete();
      for (int i = 0; i < TAPS; i++) m_coef[i] = 16'sd0;
   endtask

   task automatic write_coef(input int a, input logic signed [15:0] v);
      @(negedge clk);
      bus.coef_we   = 1'b1;
      bus.coef_addr = AW'(a);
      bus.coef_data = v;
      m_coef[a]     = v;
      @(negedge clk);
      bus.coef_we   = 1'b0;
   endtask

   // Drives one sample through a full transaction. Optional coefficient
   // write on the accept cycle (cw_en) and an attempted c[0]=100 write during
   // ISSUE (poke). lat = posedges from accept to out_valid observed.
   task automatic send_sample(input logic signed [15:0] d, input bit cw_en, input int cw_addr,
                              input logic signed [15:0] cw_data, input bit poke, input int rdly,
                              output logic [ACC_W-1:0] y, output logic [ACC_W-1:0] expv,
                              output int lat, output bit ok);
      int n;
      ok = 1'b1; y = '0; expv = '0; lat = 0;
      @(negedge clk);
      n = 0;
      while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
      if (!bus.in_ready) begin ok = 1'b0; return; end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      if (cw_en) begin
         bus.coef_we     = 1'b1;
         bus.coef_addr   = AW'(cw_addr);
         bus.coef_data   = cw_data;
         m_coef[cw_addr] = cw_data;
      end
      expv = model_push(d);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.coef_we  = 1'b0;
      bus.in_data  = 16'($urandom);
      while (!bus.out_valid && lat < 40) begin
         if (poke && lat < 3) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = '0;
            bus.coef_data = 16'sd100;
         end else begin
            bus.coef_we = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      bus.coef_we = 1'b0;
      if (!bus.out_valid) begin ok = 1'b0; return; end
      y = bus.out_data;
      repeat (rdly) @(negedge clk);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.busy, bus.alu_op_sel, bus.alu_a, bus.alu_b} !==
          {1'b0, 1'b0, 1'b0, 2'b11, 16'h0, 16'h0}) begin
         n_bad++;
         $display("FAIL reset_ctrl: got rdy=%b vld=%b busy=%b op=%b a=%h b=%h want 0 0 0 11 0000 0000",
                  bus.in_ready, bus.out_valid, bus.busy, bus.alu_op_sel, bus.alu_a, bus.alu_b);
      end
      n_cmp++;
      if (bus.out_data !== '0) begin
         n_bad++;
         $display("FAIL reset_data: got %h want 0", bus.out_data);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release: got rdy=%b busy=%b want 1 0", bus.in_ready, bus.busy);
      end
      model_reset();
   endtask

   task automatic run_impulse(input string tag);
      logic [ACC_W-1:0] y, e, want;
      int lat; bit ok;
      for (int i = 0; i < TAPS; i++) write_coef(i, 16'(i + 1));
      for (int i = 0; i < TAPS + 1; i++) begin
         send_sample((i == 0) ? 16'sd1 : 16'sd0, 1'b0, 0, 16'sd0, 1'b0, 0, y, e, lat, ok);
         want = (i < TAPS) ? ACC_W'(i + 1) : '0;
         n_cmp++;
         if (!ok || y !== want) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0d (ok=%0b) want %0d", tag, i, $signed(y), ok, $signed(want));
         end
      end
   endtask

   task automatic test_impulse();
      run_impulse("impulse");
   endtask

   task automatic test_alu_sequence();
      logic signed [15:0] d;
      logic [ACC_W-1:0] e;
      int first_v, n;
      for (int i = 0; i < TAPS; i++) write_coef(i, 16'($urandom));
      d = 16'($urandom);
      @(negedge clk);
      n = 0;
      while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      e = model_push(d);
      @(negedge clk);
      bus.in_valid = 1'b0;
      first_v = -1;
      for (int j = 0; j < 12; j++) begin
         n_cmp++;
         if (j < TAPS) begin
            if ({bus.alu_op_sel, bus.alu_a, bus.alu_b} !== {2'b01, hist_at(j), m_coef[j]}) begin
               n_bad++;
               $display("FAIL alu_seq[%0d]: got op=%b a=%h b=%h want op=01 a=%h b=%h",
                        j, bus.alu_op_sel, bus.alu_a, bus.alu_b, hist_at(j), m_coef[j]);
            end
         end else if ({bus.alu_op_sel, bus.alu_a, bus.alu_b} !== {2'b11, 32'h0}) begin
            n_bad++;
            $display("FAIL alu_idle[%0d]: got op=%b a=%h b=%h want op=11 a=0 b=0",
                     j, bus.alu_op_sel, bus.alu_a, bus.alu_b);
         end
         if (bus.out_valid && first_v < 0) first_v = j;
         @(negedge clk);
      end
      n_cmp++;
      if (first_v != TAPS + 1) begin
         n_bad++;
         $display("FAIL latency: got %0d edges want %0d", first_v, TAPS + 1);
      end
      n_cmp++;
      if (bus.out_data !== e) begin
         n_bad++;
         $display("FAIL alu_seq_result: got %0d want %0d", $signed(bus.out_data), $signed(e));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_worst_case();
      logic [ACC_W-1:0] y, e;
      int lat; bit ok;
      for (int i = 0; i < TAPS; i++) write_coef(i, 16'h8000);
      for (int i = 0; i < TAPS; i++) begin
         send_sample(16'h8000, 1'b0, 0, 16'sd0, 1'b0, 0, y, e, lat, ok);
         n_cmp++;
         if (!ok || y !== e) begin
            n_bad++;
            $display("FAIL worst[%0d]: got %0d want %0d", i, $signed(y), $signed(e));
         end
      end
      n_cmp++;
      if (y !== 35'h2_0000_0000) begin
         n_bad++;
         $display("FAIL worst_final: got %0d want 8589934592", $signed(y));
      end
   endtask

   task automatic test_coef_lockout();
      logic [ACC_W-1:0] y, e;
      int lat; bit ok;
      for (int i = 0; i < TAPS; i++) write_coef(i, 16'(3 * i + 7));
      send_sample(16'sd1000, 1'b0, 0, 16'sd0, 1'b1, 0, y, e, lat, ok);
      n_cmp++;
      if (!ok || y !== e) begin
         n_bad++;
         $display("FAIL lockout_cur: got %0d want %0d", $signed(y), $signed(e));
      end
      send_sample(-16'sd321, 1'b0, 0, 16'sd0, 1'b0, 0, y, e, lat, ok);
      n_cmp++;
      if (!ok || y !== e) begin
         n_bad++;
         $display("FAIL lockout_next: got %0d want %0d", $signed(y), $signed(e));
      end
   endtask

   task automatic test_coef_on_accept();
      logic [ACC_W-1:0] y, e;
      int lat; bit ok;
      send_sample(16'sd5, 1'b1, 0, 16'sd500, 1'b0, 1, y, e, lat, ok);
      n_cmp++;
      if (!ok || y !== e) begin
         n_bad++;
         $display("FAIL coef_on_accept: got %0d want %0d", $signed(y), $signed(e));
      end
   endtask

   task automatic test_backpressure();
      logic signed [15:0] d1, d2;
      logic [ACC_W-1:0] e1, e2;
      int n;
      d1 = 16'($urandom);
      d2 = 16'($urandom);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d1;
      e1 = model_push(d1);
      @(negedge clk);
      bus.in_data  = d2;
      n = 0;
      while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
      for (int j = 0; j < 5; j++) begin
         n_cmp++;
         if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b101 || bus.out_data !== e1) begin
            n_bad++;
            $display("FAIL backpressure[%0d]: got vld=%b rdy=%b busy=%b data=%0d want 1 0 1 %0d",
                     j, bus.out_valid, bus.in_ready, bus.busy, $signed(bus.out_data), $signed(e1));
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
         n_bad++;
         $display("FAIL bp_idle: got vld=%b rdy=%b busy=%b want 0 1 0",
                  bus.out_valid, bus.in_ready, bus.busy);
      end
      bus.out_ready = 1'b0;
      e2 = model_push(d2);
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_cmp++;
      if ({bus.busy, bus.alu_op_sel} !== 3'b101 || bus.alu_a !== d2) begin
         n_bad++;
         $display("FAIL bp_accept: got busy=%b op=%b a=%h want 1 01 %h",
                  bus.busy, bus.alu_op_sel, bus.alu_a, d2);
      end
      n = 0;
      while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
      n_cmp++;
      if (!bus.out_valid || bus.out_data !== e2) begin
         n_bad++;
         $display("FAIL bp_second: got vld=%b data=%0d want 1 %0d", bus.out_valid, $signed(bus.out_data), $signed(e2));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [ACC_W-1:0] y, e;
      int lat; bit ok;
      for (int n = 0; n < 24; n++) begin
         send_sample(16'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, TAPS - 1)),
                     16'($urandom), 1'b0, int'($urandom_range(0, 3)), y, e, lat, ok);
         n_cmp++;
         if (!ok || y !== e || lat != TAPS + 1) begin
            n_bad++;
            $display("FAIL random[%0d]: got %0d lat=%0d ok=%0b want %0d lat=%0d",
                     n, $signed(y), lat, ok, $signed(e), TAPS + 1);
         end
      end
   endtask

   task automatic test_reset_mid_issue();
      bit seen;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'sh1234;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (bus.alu_op_sel !== 2'b01) begin
         n_bad++;
         $display("FAIL mid_issue_state: got op=%b want 01", bus.alu_op_sel);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.busy, bus.alu_op_sel, bus.alu_a, bus.alu_b} !==
          {1'b0, 1'b0, 1'b0, 2'b11, 16'h0, 16'h0} || bus.out_data !== '0) begin
         n_bad++;
         $display("FAIL mid_reset: got rdy=%b vld=%b busy=%b op=%b a=%h b=%h data=%h want reset values",
                  bus.in_ready, bus.out_valid, bus.busy, bus.alu_op_sel, bus.alu_a, bus.alu_b, bus.out_data);
      end
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0 || bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL post_reset_quiet: got out_valid_seen=%b busy=%b want 0 0", seen, bus.busy);
      end
      run_impulse("post_reset_impulse");
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      bus.coef_we   = 1'b0;
      bus.coef_addr = '0;
      bus.coef_data = '0;
      test_reset();
      test_impulse();
      test_alu_sequence();
      test_worst_case();
      test_coef_lockout();
      test_coef_on_accept();
      test_backpressure();
      test_random();
      test_reset_mid_issue();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
